// File: rtl/counter_timestamp_capture.sv
// Timestamps synchronised event edges as {epoch, count} and queues them in a
// small show-ahead FIFO with a sticky overflow flag and a saturating drop counter.
module counter_timestamp_capture #(
   parameter int DEPTH   = 4,
   parameter int EPOCH_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          cnt_in,
   input  logic                 evt_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EPOCH_W+31:0]  out_data,
   output logic                 ovf,
   output logic [7:0]           drop_cnt,
   input  logic                 clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int DW = EPOCH_W + 32;

   logic               s1, s2, s3;
   logic               evt;
   logic [31:0]        cnt_prev;
   logic               wrap;
   logic [EPOCH_W-1:0] epoch;
   logic [EPOCH_W-1:0] epoch_ts;
   logic [DW-1:0]      ts;

   logic [DW-1:0]      mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [OW-1:0]      occ;
   logic [DW-1:0]      last_head;
   logic               full;
   logic               push, pop, drop;

   // s1 is the metastability catcher; the edge detect runs on s2/s3 only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= evt_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign evt = s2 & ~s3;

   // An event in the wrap cycle must already carry the incremented epoch.
   assign wrap     = (cnt_in < cnt_prev);
   assign epoch_ts = epoch + {{(EPOCH_W-1){1'b0}}, wrap};
   assign ts       = {epoch_ts, cnt_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_prev <= '0;
         epoch    <= '0;
      end else begin
         cnt_prev <= cnt_in;
         if (wrap) epoch <= epoch_ts;
      end
   end

   // Handshake: out_valid/out_ready transfer the head on every rising edge where
   // both are high; out_data is stable while out_valid is high and not accepted.
   assign full      = (occ == OW'(DEPTH));
   assign out_valid = (occ != '0);
   assign pop       = out_valid & out_ready;
   assign push      = evt & (~full | pop);
   assign drop      = evt & full & ~pop;
   assign out_data  = out_valid ? mem[rd_ptr] : last_head;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ts;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         last_head <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            last_head <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // A drop in the same cycle as clr_ovf restarts the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (clr_ovf)
            drop_cnt <= 8'd1;
         else if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule
